// File: rtl/cache_refill_fsm.sv
// -----------------------------------------------------------------------------
// cache_refill_fsm
//
// Cache-miss refill controller. It accepts a miss, picks a victim way (the
// lowest-indexed invalid way, or the LFSR's random way when the set is full),
// fetches the line as a single burst read, and streams every beat into the
// data array. It finishes by committing the tag on success or by flagging an
// error. The LFSR is advanced only when its random way was actually used.
//
// Ports
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_miss_valid / o_miss_ready  miss handshake (ready only while idle)
//   i_miss_addr                  miss byte address
//   i_way_valid                  valid bits of the indexed set
//   i_rand_way_oh                one-hot random way from the LFSR
//   o_lfsr_en                    advances the LFSR when the random way is used
//   o_mem_ar*                    burst read request (line-aligned, LINE_WORDS beats)
//   i_mem_r* / o_mem_rready      read data channel
//   o_wr_*                       data-array write port, combinational per beat
//   o_tag_we, o_done, o_err      completion pulses
//   o_busy                       high whenever a refill is in progress
// -----------------------------------------------------------------------------
module cache_refill_fsm #(
    parameter int WAYS       = 4,   // <= 8
    parameter int LINE_WORDS = 4,   // power of 2, 2..256
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_miss_valid,
    output logic                          o_miss_ready,
    input  logic [ADDR_W-1:0]             i_miss_addr,
    input  logic [WAYS-1:0]               i_way_valid,
    input  logic [WAYS-1:0]               i_rand_way_oh,
    output logic                          o_lfsr_en,
    output logic                          o_mem_arvalid,
    input  logic                          i_mem_arready,
    output logic [ADDR_W-1:0]             o_mem_araddr,
    output logic [7:0]                    o_mem_arlen,
    input  logic                          i_mem_rvalid,
    output logic                          o_mem_rready,
    input  logic [DATA_W-1:0]             i_mem_rdata,
    input  logic [1:0]                    i_mem_rresp,
    input  logic                          i_mem_rlast,
    output logic                          o_wr_en,
    output logic [WAYS-1:0]               o_wr_way_oh,
    output logic [$clog2(LINE_WORDS)-1:0] o_wr_word,
    output logic [DATA_W-1:0]             o_wr_data,
    output logic                          o_tag_we,
    output logic                          o_done,
    output logic                          o_err,
    output logic                          o_busy
);

    localparam int WORD_W = $clog2(LINE_WORDS);
    // Byte offset bits covered by one line.
    localparam int OFF_W  = $clog2(LINE_WORDS * DATA_W / 8);

    localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);
    localparam logic [7:0]        BURST_LEN = 8'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_RD,
        S_FIN
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;    // already line-aligned
    logic [WAYS-1:0]     victim_q, victim_d;
    logic [WORD_W-1:0]   cnt_q,    cnt_d;
    logic                err_q,    err_d;

    logic [WAYS-1:0]     free_way_oh;
    logic                found_free;
    logic                set_full;

    // Lowest-indexed invalid way, one-hot; all zero when the set is full.
    always_comb begin
        free_way_oh = '0;
        found_free  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!i_way_valid[w] && !found_free) begin
                free_way_oh[w] = 1'b1;
                found_free     = 1'b1;
            end
        end
    end

    assign set_full = &i_way_valid;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d       = state_q;
        addr_d        = addr_q;
        victim_d      = victim_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        o_miss_ready  = 1'b0;
        o_lfsr_en     = 1'b0;
        o_mem_arvalid = 1'b0;
        o_mem_araddr  = '0;
        o_mem_arlen   = '0;
        o_mem_rready  = 1'b0;
        o_wr_en       = 1'b0;
        o_wr_way_oh   = '0;
        o_wr_word     = '0;
        o_wr_data     = '0;
        o_tag_we      = 1'b0;
        o_done        = 1'b0;
        o_err         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                o_miss_ready = 1'b1;
                if (i_miss_valid) begin
                    addr_d   = i_miss_addr & LINE_MASK;
                    // The random way is consumed only when no way is free.
                    victim_d  = set_full ? i_rand_way_oh : free_way_oh;
                    o_lfsr_en = set_full;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    state_d   = S_AR;
                end
            end

            S_AR: begin
                o_mem_arvalid = 1'b1;
                o_mem_araddr  = addr_q;
                o_mem_arlen   = BURST_LEN;
                if (i_mem_arready) begin
                    state_d = S_RD;
                end
            end

            S_RD: begin
                o_mem_rready = 1'b1;
                if (i_mem_rvalid) begin
                    o_wr_en     = 1'b1;
                    o_wr_way_oh = victim_q;
                    o_wr_word   = cnt_q;
                    o_wr_data   = i_mem_rdata;
                    cnt_d       = cnt_q + WORD_W'(1);
                    // Sticky: bad response, or rlast disagreeing with our own
                    // beat count, in either direction.
                    if ((i_mem_rresp != 2'b00) || (i_mem_rlast != (cnt_q == LAST_WORD))) begin
                        err_d = 1'b1;
                    end
                    // The beat count, not rlast, ends the burst.
                    if (cnt_q == LAST_WORD) begin
                        state_d = S_FIN;
                    end
                end
            end

            S_FIN: begin
                o_tag_we = !err_q;
                o_done   = !err_q;
                o_err    = err_q;
                state_d  = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign o_busy = (state_q != S_IDLE);

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            victim_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            victim_q <= victim_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_cache_refill_fsm.sv
// -----------------------------------------------------------------------------
// tb_cache_refill_fsm
//
// Drives directed and randomized refills into cache_refill_fsm. A transaction
// level reference (open miss, request accepted, beats received so far) predicts
// every output each cycle from the current inputs; directed runs additionally
// pin hand-computed values such as the victim, aligned address and done cycle.
// -----------------------------------------------------------------------------
module tb_cache_refill_fsm;

    localparam int WAYS       = 4;
    localparam int LW         = 4;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int WORD_W     = $clog2(LW);
    localparam int LINE_BYTES = LW * DATA_W / 8;

    logic                i_clk = 1'b0;
    logic                i_rst;
    logic                i_miss_valid;
    logic                o_miss_ready;
    logic [ADDR_W-1:0]   i_miss_addr;
    logic [WAYS-1:0]     i_way_valid;
    logic [WAYS-1:0]     i_rand_way_oh;
    logic                o_lfsr_en;
    logic                o_mem_arvalid;
    logic                i_mem_arready;
    logic [ADDR_W-1:0]   o_mem_araddr;
    logic [7:0]          o_mem_arlen;
    logic                i_mem_rvalid;
    logic                o_mem_rready;
    logic [DATA_W-1:0]   i_mem_rdata;
    logic [1:0]          i_mem_rresp;
    logic                i_mem_rlast;
    logic                o_wr_en;
    logic [WAYS-1:0]     o_wr_way_oh;
    logic [WORD_W-1:0]   o_wr_word;
    logic [DATA_W-1:0]   o_wr_data;
    logic                o_tag_we;
    logic                o_done;
    logic                o_err;
    logic                o_busy;

    cache_refill_fsm #(
        .WAYS(WAYS), .LINE_WORDS(LW), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_miss_valid(i_miss_valid), .o_miss_ready(o_miss_ready),
        .i_miss_addr(i_miss_addr), .i_way_valid(i_way_valid),
        .i_rand_way_oh(i_rand_way_oh), .o_lfsr_en(o_lfsr_en),
        .o_mem_arvalid(o_mem_arvalid), .i_mem_arready(i_mem_arready),
        .o_mem_araddr(o_mem_araddr), .o_mem_arlen(o_mem_arlen),
        .i_mem_rvalid(i_mem_rvalid), .o_mem_rready(o_mem_rready),
        .i_mem_rdata(i_mem_rdata), .i_mem_rresp(i_mem_rresp),
        .i_mem_rlast(i_mem_rlast), .o_wr_en(o_wr_en),
        .o_wr_way_oh(o_wr_way_oh), .o_wr_word(o_wr_word),
        .o_wr_data(o_wr_data), .o_tag_we(o_tag_we), .o_done(o_done),
        .o_err(o_err), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [WAYS-1:0]   way;
        int                word;
        logic [DATA_W-1:0] data;
        int                cyc;
    } wr_t;

    wr_t wr_q[$];
    int  lfsr_cnt = 0, lfsr_cyc = -1;
    int  done_cnt = 0, done_cyc = -1;
    int  err_cnt  = 0, tag_cnt  = 0;
    logic [ADDR_W-1:0] ar_seen = '0;
    int  acc_cyc  = 0;

    // ---------------- reference model state ----------------
    bit                m_open    = 1'b0;  // a miss has been accepted and not finished
    bit                m_ar_done = 1'b0;  // burst request accepted by memory
    int                m_beats   = 0;     // beats received so far
    bit                m_bad     = 1'b0;  // any beat violated the protocol
    logic [ADDR_W-1:0] m_line    = '0;
    logic [WAYS-1:0]   m_victim  = '0;

    // expected outputs for the current cycle
    logic              e_ready, e_lfsr, e_arvalid, e_rready, e_wr_en;
    logic              e_tag_we, e_done, e_err, e_busy;
    logic [ADDR_W-1:0] e_araddr;
    logic [7:0]        e_arlen;
    logic [WAYS-1:0]   e_way;
    logic [WORD_W-1:0] e_word;
    logic [DATA_W-1:0] e_data;

    function automatic logic [WAYS-1:0] pick_victim(input logic [WAYS-1:0] wv,
                                                    input logic [WAYS-1:0] roh);
        for (int i = 0; i < WAYS; i++) begin
            if (!wv[i]) return WAYS'(1) << i;
        end
        return roh;
    endfunction

    function automatic void compute_expected();
        e_ready = 1'b0; e_lfsr = 1'b0; e_arvalid = 1'b0; e_rready = 1'b0;
        e_wr_en = 1'b0; e_tag_we = 1'b0; e_done = 1'b0; e_err = 1'b0;
        e_busy = 1'b0; e_araddr = '0; e_arlen = '0; e_way = '0;
        e_word = '0; e_data = '0;
        if (i_rst) begin
            e_ready = 1'b1;
        end else if (!m_open) begin
            e_ready = 1'b1;
            e_lfsr  = i_miss_valid && (i_way_valid == {WAYS{1'b1}});
        end else if (!m_ar_done) begin
            e_busy    = 1'b1;
            e_arvalid = 1'b1;
            e_araddr  = m_line;
            e_arlen   = 8'(LW - 1);
        end else if (m_beats < LW) begin
            e_busy   = 1'b1;
            e_rready = 1'b1;
            if (i_mem_rvalid) begin
                e_wr_en = 1'b1;
                e_way   = m_victim;
                e_word  = WORD_W'(m_beats);
                e_data  = i_mem_rdata;
            end
        end else begin
            e_busy   = 1'b1;
            e_tag_we = !m_bad;
            e_done   = !m_bad;
            e_err    = m_bad;
        end
    endfunction

    function automatic void model_step();
        if (i_rst) begin
            m_open = 1'b0; m_ar_done = 1'b0; m_beats = 0; m_bad = 1'b0;
            m_line = '0; m_victim = '0;
        end else if (!m_open) begin
            if (i_miss_valid) begin
                m_open    = 1'b1;
                m_ar_done = 1'b0;
                m_beats   = 0;
                m_bad     = 1'b0;
                m_line    = i_miss_addr - (i_miss_addr % LINE_BYTES);
                m_victim  = pick_victim(i_way_valid, i_rand_way_oh);
            end
        end else if (!m_ar_done) begin
            if (i_mem_arready) m_ar_done = 1'b1;
        end else if (m_beats < LW) begin
            if (i_mem_rvalid) begin
                if (i_mem_rresp != 2'b00 || i_mem_rlast != (m_beats == LW - 1)) m_bad = 1'b1;
                m_beats++;
            end
        end else begin
            m_open = 1'b0;
        end
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare_cycle();
        compute_expected();
        check("miss_ready", o_miss_ready, e_ready);
        check("lfsr_en",    o_lfsr_en,    e_lfsr);
        check("arvalid",    o_mem_arvalid, e_arvalid);
        check("araddr",     o_mem_araddr, e_araddr);
        check("arlen",      o_mem_arlen,  e_arlen);
        check("rready",     o_mem_rready, e_rready);
        check("wr_en",      o_wr_en,      e_wr_en);
        check("wr_way",     o_wr_way_oh,  e_way);
        check("wr_word",    o_wr_word,    e_word);
        check("wr_data",    o_wr_data,    e_data);
        check("tag_we",     o_tag_we,     e_tag_we);
        check("done",       o_done,       e_done);
        check("err",        o_err,        e_err);
        check("busy",       o_busy,       e_busy);
        if (!i_rst) begin
            if (o_wr_en) wr_q.push_back('{o_wr_way_oh, int'(o_wr_word), o_wr_data, cyc});
            if (o_lfsr_en) begin lfsr_cnt++; lfsr_cyc = cyc; end
            if (o_done) begin done_cnt++; done_cyc = cyc; end
            if (o_err) err_cnt++;
            if (o_tag_we) tag_cnt++;
            if (o_mem_arvalid) ar_seen = o_mem_araddr;
        end
    endtask

    // ---------------- one refill ----------------
    // stall_mode: 0 rvalid held high, 1 pattern 1,0,0 repeating, 2 random.
    // resp_beat: beat index carrying a bad response (-1 none).
    // rlast_beat: beat index carrying rlast (LW means none).
    // rst_after: assert reset right after this beat index (-1 none).
    task automatic run_miss(input logic [WAYS-1:0] wv, input logic [WAYS-1:0] roh,
                            input logic [ADDR_W-1:0] addr, input int ar_delay,
                            input int stall_mode, input int resp_beat, input int rlast_beat,
                            input int rst_after, input bit seq_data,
                            input logic [DATA_W-1:0] base);
        int  guard;
        int  b;
        int  k;
        bit  v;
        guard = 0;
        while (o_busy && guard < 50) begin
            @(posedge i_clk); #1;
            guard++;
        end
        check("idle_timeout", o_busy, 0);

        i_miss_valid  = 1'b1;
        i_miss_addr   = addr;
        i_way_valid   = wv;
        i_rand_way_oh = roh;
        acc_cyc       = cyc;
        @(posedge i_clk); #1;
        i_miss_valid  = 1'b0;
        i_miss_addr   = $urandom;
        i_way_valid   = WAYS'($urandom);
        i_rand_way_oh = WAYS'($urandom);

        // rvalid noise while the request is pending must be ignored
        for (int d = 0; d < ar_delay; d++) begin
            i_mem_rvalid = 1'($urandom);
            i_mem_rdata  = $urandom;
            @(posedge i_clk); #1;
        end
        i_mem_rvalid  = 1'b0;
        i_mem_arready = 1'b1;
        @(posedge i_clk); #1;

        b = 0; k = 0; guard = 0;
        while (b < LW && guard < 200) begin
            case (stall_mode)
                0:       v = 1'b1;
                1:       v = (k % 3 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            i_mem_rvalid  = v;
            i_mem_rdata   = seq_data ? base + DATA_W'(b) : $urandom;
            i_mem_rresp   = (b == resp_beat) ? 2'($urandom_range(1, 3)) : 2'b00;
            i_mem_rlast   = (b == rlast_beat);
            i_mem_arready = 1'($urandom);
            @(posedge i_clk); #1;
            k++; guard++;
            if (v) begin
                b++;
                if (rst_after >= 0 && b == rst_after + 1) begin
                    i_rst = 1'b1;
                    #1;
                    check("rst_now_ready",   o_miss_ready,  1);
                    check("rst_now_busy",    o_busy,        0);
                    check("rst_now_wr_en",   o_wr_en,       0);
                    check("rst_now_rready",  o_mem_rready,  0);
                    check("rst_now_arvalid", o_mem_arvalid, 0);
                    i_mem_rvalid  = 1'b0;
                    i_mem_rlast   = 1'b0;
                    i_mem_rresp   = 2'b00;
                    i_mem_arready = 1'b0;
                    repeat (2) @(posedge i_clk);
                    #1 i_rst = 1'b0;
                    return;
                end
            end
        end
        check("beat_timeout", b, LW);
        i_mem_rvalid  = 1'b0;
        i_mem_rlast   = 1'b0;
        i_mem_rresp   = 2'b00;
        i_mem_arready = 1'b0;
        @(posedge i_clk); #1;   // FIN
    endtask

    // ---------------- main ----------------
    initial begin
        int wb, lb, db, eb, tb;

        i_rst = 1'b1;
        i_miss_valid = 1'b0; i_miss_addr = '0; i_way_valid = '0; i_rand_way_oh = '0;
        i_mem_arready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
        i_mem_rresp = 2'b00; i_mem_rlast = 1'b0;

        fork
            forever @(posedge i_clk) cyc++;
            forever @(posedge i_clk or posedge i_rst) model_step();
            forever @(negedge i_clk) compare_cycle();
            begin
                #2000000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1);
            end
        join_none

        repeat (3) @(posedge i_clk);
        #1;
        check("reset_ready", o_miss_ready, 1);
        check("reset_busy",  o_busy,       0);
        check("reset_arlen", o_mem_arlen,  0);
        i_rst = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;

        // Invalid-way priority
        wb = wr_q.size(); lb = lfsr_cnt; db = done_cnt;
        run_miss(4'b1011, 4'b0001, 32'h8000_001C, 0, 0, -1, LW - 1, -1, 1'b1, 32'hA0);
        check("t1_lfsr_cnt", lfsr_cnt - lb, 0);
        check("t1_nwrites",  wr_q.size() - wb, 4);
        for (int i = 0; i < 4 && wb + i < wr_q.size(); i++) begin
            check("t1_way",  wr_q[wb + i].way,  4'b0100);
            check("t1_word", wr_q[wb + i].word, i);
            check("t1_data", wr_q[wb + i].data, 32'hA0 + i);
        end
        check("t1_araddr",   ar_seen, 32'h8000_0010);
        check("t1_done_cnt", done_cnt - db, 1);
        check("t1_done_at",  done_cyc - acc_cyc, 6);

        // Random victim
        wb = wr_q.size(); lb = lfsr_cnt; db = done_cnt; tb = tag_cnt;
        run_miss(4'b1111, 4'b0010, 32'h0000_1234, 0, 0, -1, LW - 1, -1, 1'b0, '0);
        check("t2_lfsr_cnt", lfsr_cnt - lb, 1);
        check("t2_lfsr_at",  lfsr_cyc - acc_cyc, 0);
        check("t2_nwrites",  wr_q.size() - wb, 4);
        for (int i = wb; i < wr_q.size(); i++) check("t2_way", wr_q[i].way, 4'b0010);
        check("t2_done_cnt", done_cnt - db, 1);
        check("t2_tag_cnt",  tag_cnt - tb, 1);

        // Backpressure
        wb = wr_q.size(); db = done_cnt;
        run_miss(4'b0111, 4'b0100, 32'h4000_0044, 3, 1, -1, LW - 1, -1, 1'b1, 32'h50);
        check("t3_nwrites", wr_q.size() - wb, 4);
        for (int i = 0; i < 4 && wb + i < wr_q.size(); i++) begin
            check("t3_word", wr_q[wb + i].word, i);
            check("t3_way",  wr_q[wb + i].way,  4'b1000);
        end
        check("t3_araddr",   ar_seen, 32'h4000_0040);
        check("t3_done_cnt", done_cnt - db, 1);
        if (wr_q.size() > 0) check("t3_done_at", done_cyc - wr_q[wr_q.size() - 1].cyc, 1);

        // Errors: bad response on beat 1, then early rlast on beat 2
        for (int run = 0; run < 2; run++) begin
            wb = wr_q.size(); db = done_cnt; eb = err_cnt; tb = tag_cnt;
            if (run == 0) run_miss(4'b0000, 4'b0001, $urandom, 1, 0, 1, LW - 1, -1, 1'b0, '0);
            else          run_miss(4'b0000, 4'b0001, $urandom, 0, 0, -1, 2, -1, 1'b0, '0);
            check("t4_nwrites", wr_q.size() - wb, 4);
            check("t4_err_cnt", err_cnt - eb, 1);
            check("t4_done_cnt", done_cnt - db, 0);
            check("t4_tag_cnt", tag_cnt - tb, 0);
            check("t4_idle", o_busy, 0);
        end

        // Reset mid-burst, then a full refill
        wb = wr_q.size();
        run_miss(4'b1101, 4'b0001, 32'h0000_0F00, 0, 0, -1, LW - 1, 1, 1'b0, '0);
        check("t5_partial_writes", wr_q.size() - wb, 2);
        wb = wr_q.size(); db = done_cnt;
        run_miss(4'b1101, 4'b0001, 32'h0000_0F08, 0, 0, -1, LW - 1, -1, 1'b1, 32'hC0);
        check("t5_nwrites", wr_q.size() - wb, 4);
        for (int i = 0; i < 4 && wb + i < wr_q.size(); i++) begin
            check("t5_word", wr_q[wb + i].word, i);
            check("t5_way",  wr_q[wb + i].way,  4'b0010);
            check("t5_data", wr_q[wb + i].data, 32'hC0 + i);
        end
        check("t5_done_cnt", done_cnt - db, 1);

        // Randomized refills checked cycle by cycle against the model
        for (int n = 0; n < 40; n++) begin
            logic [WAYS-1:0] roh;
            int rb, lbt, ra;
            roh = ($urandom_range(0, 7) == 0) ? WAYS'($urandom)
                                              : WAYS'(1) << $urandom_range(0, WAYS - 1);
            rb  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, LW - 1) : -1;
            lbt = ($urandom_range(0, 5) == 0) ? $urandom_range(0, LW) : LW - 1;
            ra  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 2) : -1;
            run_miss(($urandom_range(0, 2) == 0) ? {WAYS{1'b1}} : WAYS'($urandom),
                     roh, $urandom, $urandom_range(0, 3),
                     ($urandom_range(0, 1) == 0) ? 0 : 2, rb, lbt, ra, 1'b0, '0);
            repeat ($urandom_range(0, 2)) @(posedge i_clk);
            #1;
        end

        repeat (3) @(posedge i_clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_refill_fsm.md
# cache_refill_fsm

Cache-miss refill controller that sits directly downstream of the 8-bit LFSR way picker. On a miss it picks a victim way: the lowest-indexed invalid way if one exists, otherwise the LFSR's one-hot random way. It then fetches the whole line from memory as one AXI-style burst and streams each beat into the selected way of the data array. On completion it commits the tag, or reports an error, and pulses the LFSR enable only when the random choice was actually consumed.

## Interface
- WAYS, 4: number of ways; must be ≤ 8, since the LFSR supplies at most 8 ways.
- LINE_WORDS, 4: words per line; must be a power of 2, range 2..256.
- ADDR_W, 32: address width.
- DATA_W, 32: data and beat width.

Ports (clock and reset first):
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_miss_valid  in  1  miss request.
- o_miss_ready  out  1  high only in IDLE.
- i_miss_addr  in  ADDR_W  miss byte address.
- i_way_valid  in  WAYS  valid bits of the indexed set; sampled at miss acceptance.
- i_rand_way_oh  in  WAYS  one-hot random way from the LFSR.
- o_lfsr_en  out  1  one-cycle pulse that advances the LFSR.
- o_mem_arvalid  out  1  burst read request valid.
- i_mem_arready  in  1  burst read request accept.
- o_mem_araddr  out  ADDR_W  line-aligned address.
- o_mem_arlen  out  8  equals LINE_WORDS-1.
- i_mem_rvalid  in  1  read beat valid.
- o_mem_rready  out  1  read beat accept.
- i_mem_rdata  in  DATA_W  beat data.
- i_mem_rresp  in  2  beat response; nonzero means error.
- i_mem_rlast  in  1  last beat marker.
- o_wr_en  out  1  data-array write strobe.
- o_wr_way_oh  out  WAYS  target way, one-hot.
- o_wr_word  out  $clog2(LINE_WORDS)  word index within the line.
- o_wr_data  out  DATA_W  write data.
- o_tag_we  out  1  tag/valid commit pulse.
- o_done  out  1  successful refill pulse.
- o_err  out  1  failed refill pulse.
- o_busy  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, AR, RD, FIN.
- IDLE:
  - o_miss_ready=1.
  - On i_miss_valid & o_miss_ready, latch the address and victim, clear the beat counter and error flag, and go to AR.
- Victim selection at acceptance:
  - If any i_way_valid bit is 0, the victim is the lowest-indexed 0 bit and o_lfsr_en stays 0.
  - Otherwise the victim is i_rand_way_oh and o_lfsr_en=1 in the acceptance cycle only.
  - A non-one-hot i_rand_way_oh is not checked; it is used as given.
- AR:
  - o_mem_arvalid=1.
  - o_mem_araddr = latched address with its low $clog2(LINE_WORDS*DATA_W/8) bits zeroed.
  - araddr and arlen stay stable until i_mem_arready; then go to RD.
- RD:
  - o_mem_rready=1.
  - Every beat (i_mem_rvalid & rready) produces o_wr_en=1 in the same cycle, combinationally, with o_wr_way_oh=victim, o_wr_word=counter, o_wr_data=i_mem_rdata. The counter then increments.
  - The error flag is sticky. It is set by:
    - i_mem_rresp≠0 on any beat;
    - i_mem_rlast=1 on any beat other than the last;
    - i_mem_rlast=0 on the last beat.
  - The beat count is authoritative: the RD→FIN transition happens on beat LINE_WORDS-1 regardless of rlast.
  - Beats are written even when errored.
- FIN, one cycle:
  - Error flag clear: o_tag_we=1 and o_done=1.
  - Error flag set: o_err=1 and o_tag_we=0.
  - Then go to IDLE.
- Reset (any time, including mid-burst):
  - State returns to IDLE.
  - Counter, error flag and victim are cleared.
  - An in-flight memory transaction is abandoned; the memory side shares the reset.
- Reset values: o_miss_ready=1; every other output is 0.

## Timing
- Miss accepted at cycle T.
- o_mem_arvalid rises at T+1.
- With arready at T+1 and rvalid held high, beats fall at T+2 .. T+1+LINE_WORDS.
- FIN occurs at T+2+LINE_WORDS; o_miss_ready is back at T+3+LINE_WORDS.
- Minimum refill is LINE_WORDS+3 cycles from acceptance to the next ready.
- o_mem_rready is high for every RD cycle, so rvalid stalls simply extend RD.
- o_lfsr_en, o_tag_we, o_done and o_err are single-cycle pulses. o_done and o_err never assert together.
- Back-to-back misses are accepted only after FIN; there is no overlap.

## Test plan
- Invalid-way priority:
  - Stimulus: i_way_valid=4'b1011, i_miss_addr=0x8000_001C, arready immediate, 4 beats 0xA0..0xA3 with rlast on beat 3.
  - Response: victim 4'b0100, o_lfsr_en never asserts, araddr=0x8000_0010, writes words 0..3 with data 0xA0..0xA3, o_done at T+6.
- Random victim:
  - Stimulus: i_way_valid=4'b1111, i_rand_way_oh=4'b0010.
  - Response: o_lfsr_en pulses exactly at T, every o_wr_way_oh=4'b0010, o_tag_we together with o_done.
- Backpressure:
  - Stimulus: arready delayed 3 cycles; rvalid toggles 1,0,0,1,...
  - Response: araddr stable during the wait, exactly 4 writes with words in order, o_done one cycle after the 4th beat.
- Errors:
  - Stimulus: rresp=2'b10 on beat 1 (run 1); rlast on beat 2 (run 2).
  - Response: both runs finish after 4 beats, assert o_err with o_tag_we=0, and return to IDLE.
- Reset mid-burst:
  - Stimulus: assert i_rst after beat 1.
  - Response: outputs immediately go to their reset values (o_miss_ready=1, the rest 0). A subsequent miss refills fully, with the counter restarting at 0.
